// File: rtl/uart_tx_arb.sv
// uart_tx_arb -- two-requester round-robin front end for a uart_tx.
//
// Accepts one byte at a time from two valid/ready requesters, hands it to the
// downstream uart_tx as po_data with a one-cycle po_flag, then stays busy for
// one full frame time (10 bit periods) before it accepts the next byte.
//
// Ports
//   sys_clk, sys_rst_n     clock, asynchronous active-low reset
//   reqN_data/valid/ready  requester N handshake (N = 0, 1); ready is combinational
//   po_data, po_flag       byte and start pulse to uart_tx
//   tx_busy                high in LOAD and WAIT
//   tx_done                one-cycle pulse on the first IDLE cycle after WAIT
//   tx_src                 requester whose byte is on po_data
module uart_tx_arb #(
  parameter int UART_BPS = 9600,
  parameter int CLK_FREQ = 50_000_000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [7:0] req0_data,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [7:0] req1_data,
  input  logic       req1_valid,
  output logic       req1_ready,
  output logic [7:0] po_data,
  output logic       po_flag,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_src
);

  localparam int NUM_REQ      = 2;
  localparam int BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
  localparam int FRAME_CYCLES = BAUD_CNT_MAX * 10;
  localparam int CNT_W        = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT} state_t;

  state_t                          state;
  logic [CNT_W-1:0]                cnt;
  logic                            rr_last;   // index served most recently
  logic                            grant;
  logic                            xfer;
  logic [NUM_REQ-1:0][7:0]         req_data;
  logic [NUM_REQ-1:0]              req_valid;
  logic [NUM_REQ-1:0]              req_ready;

  assign req_data  = {req1_data, req0_data};
  assign req_valid = {req1_valid, req0_valid};

  // A lone requester always wins; on contention the one not served last wins.
  always_comb begin
    grant = ~rr_last;
    if (req_valid == 2'b01)      grant = 1'b0;
    else if (req_valid == 2'b10) grant = 1'b1;
  end

  // Grant is a single bit, so at most one ready can be high.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_rdy
    assign req_ready[i] = (state == IDLE) && req_valid[i] && (grant == 1'(i));
  end

  assign req0_ready = req_ready[0];
  assign req1_ready = req_ready[1];
  assign xfer       = |req_ready;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      rr_last <= 1'b1;    // makes requester 0 win the first contest
      po_data <= 8'd0;
      po_flag <= 1'b0;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
      tx_src  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          tx_done <= 1'b0;
          if (xfer) begin
            state   <= LOAD;
            po_data <= req_data[grant];
            tx_src  <= grant;
            rr_last <= grant;
            po_flag <= 1'b1;
            tx_busy <= 1'b1;
          end
        end
        LOAD: begin
          po_flag <= 1'b0;
          cnt     <= '0;
          state   <= WAIT;
        end
        WAIT: begin
          if (cnt == CNT_LAST) begin
            cnt     <= '0;
            state   <= IDLE;
            tx_busy <= 1'b0;
            tx_done <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          po_flag <= 1'b0;
          tx_busy <= 1'b0;
          tx_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb -- directed bench for uart_tx_arb with a short frame
// (CLK_FREQ/UART_BPS = 10, frame = 100 cycles).
module tb_uart_tx_arb;

  localparam int CLK_FREQ = 1000;
  localparam int UART_BPS = 100;
  localparam int FRAME    = (CLK_FREQ / UART_BPS) * 10;
  localparam int BOUND    = 4 * FRAME;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic [7:0] req0_data, req1_data;
  logic       req0_valid, req1_valid;
  logic       req0_ready, req1_ready;
  logic [7:0] po_data;
  logic       po_flag, tx_busy, tx_done, tx_src;

  int n_chk  = 0;
  int n_fail = 0;

  uart_tx_arb #(.UART_BPS(UART_BPS), .CLK_FREQ(CLK_FREQ)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .req0_data (req0_data),
    .req0_valid(req0_valid),
    .req0_ready(req0_ready),
    .req1_data (req1_data),
    .req1_valid(req1_valid),
    .req1_ready(req1_ready),
    .po_data   (po_data),
    .po_flag   (po_flag),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done),
    .tx_src    (tx_src)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Ticks until po_flag is high; n is the number of ticks taken.
  task automatic wait_flag(output int n);
    n = 0;
    while (!po_flag && n < BOUND) begin tick(); n++; end
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!tx_done && n < BOUND) begin tick(); n++; end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_po_data"}, 32'(po_data), 32'h00);
    chk({tag, "_po_flag"}, 32'(po_flag), 0);
    chk({tag, "_busy"},    32'(tx_busy), 0);
    chk({tag, "_done"},    32'(tx_done), 0);
    chk({tag, "_src"},     32'(tx_src),  0);
  endtask

  initial begin
    int n;
    bit seen_done;
    sys_rst_n  = 1'b0;
    req0_data  = 8'h00; req1_data  = 8'h00;
    req0_valid = 1'b0;  req1_valid = 1'b0;
    repeat (3) tick();
    chk_reset_outs("rst");
    chk("rst_rdy0", 32'(req0_ready), 0);
    chk("rst_rdy1", 32'(req1_ready), 0);
    sys_rst_n = 1'b1;
    tick();

    // Single request from requester 0
    req0_data = 8'hA5; req0_valid = 1'b1;
    #1;
    chk("single_rdy0", 32'(req0_ready), 1);
    chk("single_rdy1", 32'(req1_ready), 0);
    tick();
    req0_valid = 1'b0;
    chk("single_flag", 32'(po_flag), 1);
    chk("single_data", 32'(po_data), 32'hA5);
    chk("single_src",  32'(tx_src),  0);
    chk("single_busy", 32'(tx_busy), 1);
    req0_valid = 1'b1; #1;
    chk("load_rdy0",   32'(req0_ready), 0);
    req0_valid = 1'b0;
    tick();
    chk("wait_flag",   32'(po_flag), 0);
    chk("wait_busy",   32'(tx_busy), 1);
    wait_done(n);
    // one tick already past po_flag, so done lands FRAME ticks later
    chk("single_done_lat", 32'(n), 32'(FRAME));
    chk("done_busy", 32'(tx_busy), 0);
    tick();
    chk("done_pulse", 32'(tx_done), 0);

    // Busy blocking: req1 rises mid-WAIT, accepted on the tx_done cycle
    req0_data = 8'h33; req0_valid = 1'b1;
    tick();
    req0_valid = 1'b0;
    chk("blk_data0", 32'(po_data), 32'h33);
    repeat (10) tick();
    req1_data = 8'h44; req1_valid = 1'b1;
    n = 0;
    while (!tx_done && n < BOUND) begin
      #1;
      if (req1_ready !== 1'b0 || po_data !== 8'h33) begin
        chk("blk_wait_rdy1", 32'(req1_ready), 0);
        chk("blk_wait_data", 32'(po_data), 32'h33);
      end
      tick(); n++;
    end
    chk("blk_wait_len", 32'(n), 32'(FRAME - 9));
    chk("blk_done_rdy1", 32'(req1_ready), 1);
    chk("blk_done_done", 32'(tx_done), 1);
    tick();
    req1_valid = 1'b0;
    chk("blk_flag", 32'(po_flag), 1);
    chk("blk_data", 32'(po_data), 32'h44);
    chk("blk_src",  32'(tx_src),  1);

    // Reset mid-frame aborts with no tx_done
    repeat (50) tick();
    chk("mid_busy_pre", 32'(tx_busy), 1);
    sys_rst_n = 1'b0;
    #1;
    chk_reset_outs("mid");
    repeat (2) tick();
    sys_rst_n = 1'b1;
    seen_done = 1'b0;
    for (int i = 0; i < FRAME + 5; i++) begin
      tick();
      if (tx_done) seen_done = 1'b1;
    end
    chk("mid_no_done", 32'(seen_done), 0);
    req1_data = 8'h5A; req1_valid = 1'b1;
    #1;
    chk("mid_rdy1", 32'(req1_ready), 1);
    tick();
    req1_valid = 1'b0;
    chk("mid_flag", 32'(po_flag), 1);
    chk("mid_data", 32'(po_data), 32'h5A);
    chk("mid_src",  32'(tx_src),  1);

    // Contention and fairness right after a fresh reset
    sys_rst_n = 1'b0;
    tick();
    sys_rst_n = 1'b1;
    tick();
    req0_data = 8'h01; req1_data = 8'h02;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk("cont_rdy0", 32'(req0_ready), 1);
    chk("cont_rdy1", 32'(req1_ready), 0);
    tick();
    chk("cont_src0",  32'(tx_src),  0);
    chk("cont_data0", 32'(po_data), 32'h01);
    for (int f = 1; f < 4; f++) begin
      tick();
      wait_flag(n);
      chk($sformatf("fair_gap%0d", f), 32'(n + 1), 32'(FRAME + 2));
      chk($sformatf("fair_src%0d", f), 32'(tx_src), 32'(f % 2));
      chk($sformatf("fair_data%0d", f), 32'(po_data), (f % 2) ? 32'h02 : 32'h01);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    wait_done(n);
    chk("final_done", 32'(tx_done), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
